// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional feature macro: FETCH_PERF_EN (see fetch_sequencer.sv).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int unsigned FETCH_BUF_DEPTH  = 2;
  localparam int unsigned FETCH_CNT_W      = $clog2(FETCH_BUF_DEPTH + 1);
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;

  // True when a byte address sits on a 4-byte instruction boundary.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding {pc, instr} pairs between fetch and decode.
// A full buffer still accepts a push when the head is popped in the same cycle.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [PC_W-1:0]        push_pc,
  input  logic [31:0]            push_instr,
  input  logic                   pop,
  output logic [FETCH_CNT_W-1:0] count,
  output logic [PC_W-1:0]        head_pc,
  output logic [31:0]            head_instr
);

  localparam logic [FETCH_CNT_W-1:0] FULL = FETCH_CNT_W'(FETCH_BUF_DEPTH);

  logic [PC_W-1:0] pc_q    [FETCH_BUF_DEPTH];
  logic [31:0]     instr_q [FETCH_BUF_DEPTH];
  logic            rd_ptr;
  logic            wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  // Storage, pointers and occupancy; a flush empties the buffer and wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc_q[wr_ptr]    <= push_pc;
        instr_q[wr_ptr] <= push_instr;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_pc    = (count != '0) ? pc_q[rd_ptr]    : '0;
  assign head_instr = (count != '0) ? instr_q[rd_ptr] : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the pc, reads imem one word per cycle,
// buffers fetched words and handles branch redirects and misaligned-target traps.
// Optional feature macro: FETCH_PERF_EN adds perf_fetched / perf_stalls counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic              fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stalls
`endif
);

  localparam logic [FETCH_CNT_W-1:0] FULL = FETCH_CNT_W'(FETCH_BUF_DEPTH);

  fetch_state_t           state;
  fetch_state_t           state_next;
  logic [PC_W-1:0]        pc;
  logic [PC_W-1:0]        pc_next;
  logic                   fault_next;
  logic                   push;
  logic                   flush;
  logic                   pop;
  logic                   push_ok;
  logic                   push_blocked;
  logic [FETCH_CNT_W-1:0] buf_count;

  assign imem_addr = pc[ADDR_W+1:2];
  assign out_valid = (buf_count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push_ok   = (buf_count < FULL) || ((buf_count == FULL) && pop);

  fetch_buf #(
    .PC_W (PC_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_pc    (pc),
    .push_instr (imem_instr),
    .pop        (pop),
    .count      (buf_count),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

  // State, pc and sticky fault registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      fault <= fault_next;
    end
  end

  // Next-state logic: redirects take priority, otherwise the fetch FSM decides whether to push.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    fault_next   = fault;
    push         = 1'b0;
    flush        = 1'b0;
    push_blocked = 1'b0;
    if (redirect_valid && (state != HALT)) begin
      flush = 1'b1;
      if (is_aligned(redirect_pc[1:0])) begin
        pc_next    = redirect_pc;
        state_next = fetch_en ? FETCH : IDLE;
      end else begin
        fault_next = 1'b1;
        state_next = HALT;
      end
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) state_next = FETCH;
        end
        FETCH: begin
          if (!fetch_en) begin
            state_next = IDLE;
          end else if (push_ok) begin
            push    = 1'b1;
            pc_next = pc + PC_W'(PC_INC);
          end else begin
            push_blocked = 1'b1;
            state_next   = STALL;
          end
        end
        STALL: begin
          if (!fetch_en) begin
            state_next = IDLE;
          end else if (buf_count < FULL) begin
            state_next = FETCH;
          end
        end
        default: begin
          state_next = HALT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: words pushed, and cycles spent stalled or blocked on a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if ((state == STALL) || push_blocked) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = push_blocked;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default build, FETCH_PERF_EN undefined).
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  int errors = 0;
  int checks = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  // Preloaded instruction memory: word i holds 0x1000_0000 + i.
  assign imem_instr = 32'h1000_0000 + {22'd0, imem_addr};

  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Moves to 2 time units after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Drives the directed inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic en, input logic rdy,
                               input logic rv, input logic [31:0] rpc);
    fetch_en       = en;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for a valid head, checks it, and lets it pop on the next edge.
  task automatic expectPop(input string tag, input logic [31:0] exp_pc);
    int waited = 0;
    while (out_valid !== 1'b1 && waited < 4) begin
      nextCycle();
      #1;
      waited++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_pc"}, out_pc, exp_pc);
    checkOutput({tag, "_instr"}, out_instr, 32'h1000_0000 + (exp_pc >> 2));
    nextCycle();
    #1;
  endtask

  initial begin
    $display("[TB] starting fetch_sequencer bench");

    // Reset state.
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_pc", out_pc, 32'd0);
    checkOutput("rst_instr", out_instr, 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);

    // Streaming: one instruction per cycle after one cycle of latency.
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("idle_valid", 32'(out_valid), 32'd0);
    nextCycle(); #1;
    checkOutput("fetch0_valid", 32'(out_valid), 32'd0);
    checkOutput("fetch0_state", 32'(dut.state), 32'(FETCH));
    checkOutput("fetch0_addr", 32'(imem_addr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      nextCycle(); #1;
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      checkOutput("stream_pc", out_pc, 32'(4 * k));
      checkOutput("stream_instr", out_instr, 32'h1000_0000 + 32'(k));
    end
    // Dropping fetch_en keeps the buffered word and stops fetching.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("stream3_pc", out_pc, 32'd12);
    nextCycle(); #1;
    checkOutput("drain_state", 32'(dut.state), 32'(IDLE));
    checkOutput("drain_valid", 32'(out_valid), 32'd1);
    checkOutput("drain_pc", out_pc, 32'd12);
    checkOutput("drain_addr", 32'(imem_addr), 32'd4);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    nextCycle(); #1;
    checkOutput("drained_valid", 32'(out_valid), 32'd0);

    // Back-pressure: buffer fills with pc 0,4 and the sequencer stalls.
    rst = 1'b1;
    #1 rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) nextCycle();
    #1;
    checkOutput("stall_state", 32'(dut.state), 32'(STALL));
    checkOutput("stall_addr", 32'(imem_addr), 32'd2);
    checkOutput("stall_count", 32'(dut.buf_count), 32'd2);
    checkOutput("stall_head", out_pc, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    expectPop("resume0", 32'd0);
    expectPop("resume1", 32'd4);
    expectPop("resume2", 32'd8);

    // Asynchronous reset mid-stream.
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_addr", 32'(imem_addr), 32'd0);
    checkOutput("arst_fault", 32'(fault), 32'd0);
    #2 rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Full buffer with a pop and a push in the same cycle: no stall.
    for (int i = 0; i < 3; i++) nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("full_count", 32'(dut.buf_count), 32'd2);
    checkOutput("full_head", out_pc, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("swap_count", 32'(dut.buf_count), 32'd2);
    checkOutput("swap_state", 32'(dut.state), 32'(FETCH));
    checkOutput("swap_head", out_pc, 32'd4);
    checkOutput("swap_addr", 32'(imem_addr), 32'd3);
    nextCycle(); #1;
    checkOutput("block_state", 32'(dut.state), 32'(STALL));

    // Aligned redirect while two entries are buffered.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    checkOutput("redir_squash", 32'(out_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_valid", 32'(out_valid), 32'd0);
    checkOutput("redir_count", 32'(dut.buf_count), 32'd0);
    checkOutput("redir_addr", 32'(imem_addr), 32'h10);
    checkOutput("redir_state", 32'(dut.state), 32'(FETCH));
    nextCycle(); #1;
    checkOutput("tgt0_valid", 32'(out_valid), 32'd1);
    checkOutput("tgt0_pc", out_pc, 32'h40);
    checkOutput("tgt0_instr", out_instr, 32'h1000_0010);
    nextCycle(); #1;
    checkOutput("tgt1_pc", out_pc, 32'h44);
    nextCycle();

    // Misaligned redirect traps into HALT.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h42);
    checkOutput("trap_squash", 32'(out_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("trap_fault", 32'(fault), 32'd1);
    checkOutput("trap_state", 32'(dut.state), 32'(HALT));
    checkOutput("trap_valid", 32'(out_valid), 32'd0);
    checkOutput("trap_addr", 32'(imem_addr), 32'h13);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    nextCycle(); #1;
    checkOutput("halt_addr", 32'(imem_addr), 32'h13);
    checkOutput("halt_state", 32'(dut.state), 32'(HALT));
    checkOutput("halt_fault", 32'(fault), 32'd1);
    checkOutput("halt_valid", 32'(out_valid), 32'd0);

    // Only reset clears the fault.
    rst = 1'b1;
    #1;
    checkOutput("clr_fault", 32'(fault), 32'd0);
    checkOutput("clr_addr", 32'(imem_addr), 32'd0);
    checkOutput("clr_state", 32'(dut.state), 32'(IDLE));
    #2 rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
